// File: rtl/phi_pkg.sv
// Shared constants for the PHI2 generator: strobe indices,
// default periods and FSM state encodings.
package phi_pkg;

  localparam int PHI_MIN_CYCLE = 8;

  localparam int FULL_M2 = 0;
  localparam int FULL_M1 = 1;
  localparam int FULL_P0 = 2;
  localparam int FULL_P1 = 3;
  localparam int HALF_M2 = 4;
  localparam int HALF_M1 = 5;
  localparam int HALF_P0 = 6;
  localparam int HALF_P1 = 7;
  localparam int NSTB    = 8;

  typedef logic [NSTB-1:0] phi_stb_t;

  // 8.4 fixed point periods for a 32 MHz system clock
  localparam logic [11:0] PHI_PERIOD_PAL  = 12'h208;
  localparam logic [11:0] PHI_PERIOD_NTSC = 12'h1F4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

endpackage

// File: rtl/phi_frac_acc.sv
// Period clamp and fractional accumulator; produces the
// PHI2 cycle length L whenever a latch pulse is given.
module phi_frac_acc #(
  parameter int DIV_WIDTH = 8,
  parameter int FRAC_BITS = 4,
  parameter int MIN_CYCLE = phi_pkg::PHI_MIN_CYCLE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_latch,
  input  logic                           i_first,
  input  logic [DIV_WIDTH+FRAC_BITS-1:0] i_period,
  output logic [DIV_WIDTH:0]             o_len,
  output logic [DIV_WIDTH:0]             o_len_nxt
);

  localparam int CW = DIV_WIDTH + 1;

  logic [FRAC_BITS-1:0] r_acc;
  logic [FRAC_BITS-1:0] w_acc_base;
  logic [FRAC_BITS:0]   w_sum;
  logic [CW-1:0]        r_len;
  logic [CW-1:0]        w_int;
  logic [CW-1:0]        w_clamp;

  assign w_int = {1'b0, i_period[DIV_WIDTH+FRAC_BITS-1:FRAC_BITS]};
  assign w_clamp = (w_int < CW'(MIN_CYCLE)) ? CW'(MIN_CYCLE) : w_int;

  // A fresh start discards any leftover fraction
  assign w_acc_base = i_first ? '0 : r_acc;
  assign w_sum = {1'b0, w_acc_base}
               + {1'b0, i_period[FRAC_BITS-1:0]};

  assign o_len_nxt = i_latch
                   ? w_clamp + CW'(w_sum[FRAC_BITS])
                   : r_len;
  assign o_len = r_len;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_len <= CW'(MIN_CYCLE);
    end else if (i_latch) begin
      r_acc <= w_sum[FRAC_BITS-1:0];
      r_len <= o_len_nxt;
    end
  end

endmodule

// File: rtl/phi_generator.sv
// PHI2 clock master: fractional period divider with start/stop
// FSM and the eight registered phase strobes.
module phi_generator #(
  parameter int DIV_WIDTH = 8,
  parameter int FRAC_BITS = 4,
  parameter int MIN_CYCLE = phi_pkg::PHI_MIN_CYCLE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic [DIV_WIDTH+FRAC_BITS-1:0] i_period,
  output logic                           o_phi2_out,
  output logic                           o_running,
  output logic                           o_full_m2,
  output logic                           o_full_m1,
  output logic                           o_full_p0,
  output logic                           o_full_p1,
  output logic                           o_half_m2,
  output logic                           o_half_m1,
  output logic                           o_half_p0,
  output logic                           o_half_p1
);

  import phi_pkg::*;

  localparam int CW = DIV_WIDTH + 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_len_n;
  logic [CW-1:0] w_half_n;
  logic          w_latch;
  logic          w_first;
  logic          w_wrap;
  logic          w_act_n;
  logic          w_phi_n;
  phi_stb_t      w_stb_n;
  phi_stb_t      r_stb;
  logic          r_phi;
  logic          r_run;

  phi_frac_acc #(
    .DIV_WIDTH(DIV_WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .MIN_CYCLE(MIN_CYCLE)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_latch  (w_latch),
    .i_first  (w_first),
    .i_period (i_period),
    .o_len    (w_len),
    .o_len_nxt(w_len_n)
  );

  assign w_wrap = (r_cnt == w_len - CW'(1));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_latch   = 1'b0;
    w_first   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_n = ST_RUN;
          w_cnt_n   = '0;
          w_latch   = 1'b1;
          w_first   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_wrap) begin
          w_cnt_n = '0;
          w_latch = 1'b1;
          if (!i_enable) w_state_n = ST_STOP;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Decode from next-state values so registered outputs track cnt
  assign w_half_n = w_len_n >> 1;
  assign w_act_n  = (w_state_n != ST_IDLE);
  assign w_phi_n  = (w_state_n == ST_RUN) && (w_cnt_n >= w_half_n);

  always_comb begin
    w_stb_n = '0;
    if (w_act_n) begin
      w_stb_n[FULL_M2] = (w_cnt_n == w_len_n - CW'(2));
      w_stb_n[FULL_M1] = (w_cnt_n == w_len_n - CW'(1));
      w_stb_n[FULL_P0] = (w_cnt_n == '0);
      w_stb_n[FULL_P1] = (w_cnt_n == CW'(1));
      w_stb_n[HALF_M2] = (w_cnt_n == w_half_n - CW'(2));
      w_stb_n[HALF_M1] = (w_cnt_n == w_half_n - CW'(1));
      w_stb_n[HALF_P0] = (w_cnt_n == w_half_n);
      w_stb_n[HALF_P1] = (w_cnt_n == w_half_n + CW'(1));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stb   <= '0;
      r_phi   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_stb   <= w_stb_n;
      r_phi   <= w_phi_n;
      r_run   <= w_act_n;
    end
  end

  assign o_phi2_out = r_phi;
  assign o_running  = r_run;
  assign o_full_m2  = r_stb[FULL_M2];
  assign o_full_m1  = r_stb[FULL_M1];
  assign o_full_p0  = r_stb[FULL_P0];
  assign o_full_p1  = r_stb[FULL_P1];
  assign o_half_m2  = r_stb[HALF_M2];
  assign o_half_m1  = r_stb[HALF_M1];
  assign o_half_p0  = r_stb[HALF_P0];
  assign o_half_p1  = r_stb[HALF_P1];

endmodule

// File: doc/phi_generator.md
Name: phi_generator

Overview:
- Generates a PHI2 bus clock from the fast system clock using a fractional (integer + FRAC_BITS) period divider. Used when the core must drive PHI2 itself: standalone/bench mode, or as the clock master on the expansion port.
- Emits the same eight phase strobes that the PHI2 recovery path supplies to bus logic: full/half × m2/m1/p0/p1. Downstream consumers can use either source without change.
- Supports clean start/stop and glitch-free period changes, applied only at cycle boundaries.

Parameters:
- DIV_WIDTH, 8, integer bits of the period.
- FRAC_BITS, 4, fractional bits of the period.
- MIN_CYCLE, 8, minimum PHI2 cycle length in clk cycles. Smaller periods are clamped to this.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- enable  in  1  request the generator to run.
- period  in  DIV_WIDTH+FRAC_BITS  PHI2 period in clk cycles, unsigned fixed point.
- phi2_out  out  1  generated PHI2.
- running  out  1  high while in RUN or STOPPING.
- full_m2, full_m1, full_p0, full_p1  out  1 each  strobes around the PHI2 falling edge.
- half_m2, half_m1, half_p0, half_p1  out  1 each  strobes around the PHI2 rising edge.

Behaviour:
- Reset: all outputs are 0. State is IDLE; cnt=0, acc=0, L=MIN_CYCLE, H=MIN_CYCLE/2.
- Registers:
  - cnt: DIV_WIDTH+1 bits.
  - acc: FRAC_BITS bits.
  - Latched cycle length L: DIV_WIDTH+1 bits.
  - Half point H = L>>1.
- Period latch, performed on IDLE->RUN and in RUN when cnt==L-1:
  - N = period[DIV_WIDTH+FRAC_BITS-1:FRAC_BITS], clamped to MIN_CYCLE if below it.
  - {carry, acc} <= acc + period[FRAC_BITS-1:0].
  - L <= N + carry.
  - On IDLE->RUN, acc is treated as 0 before the addition.
- All outputs are registered and describe the current cnt (zero latency relative to cnt):
  - phi2_out = (cnt >= H).
  - full_p0: cnt==0.
  - full_p1: cnt==1.
  - full_m2: cnt==L-2.
  - full_m1: cnt==L-1.
  - half_m2: cnt==H-2.
  - half_m1: cnt==H-1.
  - half_p0: cnt==H.
  - half_p1: cnt==H+1.
- State machine:
  - IDLE: cnt held 0, phi2_out=0, all strobes 0. If enable=1, next cycle is RUN with cnt=0 and full_p0=1, and the period is latched.
  - RUN: cnt increments each clk. At cnt==L-1, cnt wraps to 0 and the next period is latched. enable is sampled only at cnt==L-1; if 0, the next state is STOPPING.
  - STOPPING: lasts exactly one cycle, with cnt=0, phi2_out=0, full_p0=1 (the final falling edge is complete). Then IDLE, regardless of enable.
- enable toggling anywhere other than cnt==L-1 has no effect in RUN.
- period changes mid-cycle affect only the next cycle; the current L and H never change mid-cycle.
- MIN_CYCLE ≥ 8 guarantees that all eight strobes fall on distinct cycles and that H-2 ≥ 2.
- N = 2^DIV_WIDTH-1 with carry gives L = 2^DIV_WIDTH. This fits cnt without overflow.
- Duty cycle: low phase is H cycles, high phase is L-H cycles. For odd L the high phase is one cycle longer.
- rst asserted mid-cycle: immediate return to reset values, so phi2_out drops asynchronously. No pending stop survives reset.

Decomposition:
- Shared package phi_pkg holds:
  - Strobe index constants (FULL_M2..HALF_P1) for the strobe vector.
  - The default period constants PHI_PERIOD_PAL and PHI_PERIOD_NTSC for the system clock.
  - MIN_CYCLE.
- One natural sub-module: phi_frac_acc. It contains the period clamp and fractional accumulator, producing L on a latch pulse.
- The FSM, counter and strobe decode stay in phi_generator.

Test Plan:
1. period=0x080 (8.0), enable=1 from reset.
   - RUN from the second cycle.
   - phi2_out low at cnt 0-3, high at 4-7, repeating every 8 clk.
   - Strobes: p0@0, p1@1, hm2@2, hm1@3, hp0@4, hp1@5, m2@6, m1@7.
2. period=0x328 (50.5).
   - Cycle lengths alternate 50, 51, 50, 51 …; H=25 in both.
   - Over 1000 PHI2 cycles the total is exactly 50500 clk.
3. period=0x050 (5.0) → clamped: L=8, identical to scenario 1.
4. Stop timing:
   - Running at 8.0, deassert enable at cnt=3 and reassert at cnt=5: no effect.
   - Deassert through cnt=7: next cycle cnt=0 with full_p0=1 and running=1; the following cycle IDLE with running=0 and all strobes 0.
   - Re-enable: full_p0 is asserted the cycle after enable.
5. Change period from 0x080 to 0x100 at cnt=2: current cycle still 8 clk; the next cycle is 16 clk with H=8.
6. Assert rst during the high phase (cnt=5): phi2_out=0 and all strobes 0 immediately. With enable held, restart from cnt=0 one cycle after rst is released.
